// File: rtl/weight_stream_reader.sv
// Read-side controller for single-port block RAM: walks a wrap-around address range
// and presents the 1-cycle-latency read data as a valid/ready stream with last/done.
module weight_stream_reader #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 400,
  parameter int RAM_ADDR  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RAM_ADDR-1:0]  base_addr,
  input  logic [RAM_ADDR:0]    count,
  output logic                 mem_ce,
  output logic [RAM_ADDR-1:0]  mem_addr,
  input  logic [RAM_WIDTH-1:0] mem_rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [RAM_ADDR-1:0] ADDR_LAST = RAM_ADDR'(RAM_DEPTH - 1);
  localparam logic [RAM_ADDR:0]   CNT_ONE   = (RAM_ADDR+1)'(1);
  localparam logic [RAM_ADDR:0]   CNT_ZERO  = (RAM_ADDR+1)'(0);

  state_t                state_r;
  state_t                state_s;
  logic [RAM_ADDR-1:0]   addr_r;
  logic [RAM_ADDR-1:0]   addr_s;
  logic [RAM_ADDR:0]     count_r;
  logic [RAM_ADDR:0]     count_s;
  logic [RAM_ADDR:0]     iss_cnt_r;
  logic [RAM_ADDR:0]     iss_cnt_s;
  logic [RAM_ADDR:0]     pop_cnt_r;
  logic [RAM_ADDR:0]     pop_cnt_s;
  logic                  done_r;
  logic                  done_s;
  logic                  inflight_r;
  logic [RAM_WIDTH-1:0]  fifo_r [3];
  logic [1:0]            wr_ptr_r;
  logic [1:0]            rd_ptr_r;
  logic [1:0]            occ_r;
  logic                  ce_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  last_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [RAM_ADDR-1:0] addr_inc(input logic [RAM_ADDR-1:0] a);
    return (a == ADDR_LAST) ? RAM_ADDR'(0) : a + RAM_ADDR'(1);
  endfunction

  // Credit check counts buffered plus in-flight words so the 3-deep FIFO can never overflow.
  always_comb begin
    ce_s   = (state_r == ST_READ) && (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);
    push_s = inflight_r;
    pop_s  = (occ_r != 2'd0) && m_ready;
    last_s = (occ_r != 2'd0) && (pop_cnt_r == (count_r - CNT_ONE));
  end

  // Next-state logic for the command FSM and issue/pop bookkeeping.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    count_s   = count_r;
    iss_cnt_s = iss_cnt_r;
    pop_cnt_s = pop_cnt_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (count == CNT_ZERO) begin
            done_s = 1'b1;
          end else begin
            state_s   = ST_READ;
            addr_s    = base_addr;
            count_s   = count;
            iss_cnt_s = CNT_ZERO;
            pop_cnt_s = CNT_ZERO;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (ce_s) begin
          addr_s    = addr_inc(addr_r);
          iss_cnt_s = iss_cnt_r + CNT_ONE;
          if ((iss_cnt_r + CNT_ONE) == count_r) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DRAIN;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // The final word can only leave after every read was issued, i.e. from DRAIN.
    if (pop_s) begin
      pop_cnt_s = pop_cnt_r + CNT_ONE;
      if (last_s) begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end else begin
        done_s = done_s;
      end
    end else begin
      pop_cnt_s = pop_cnt_s;
    end
  end

  // Command state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      count_r   <= '0;
      iss_cnt_r <= '0;
      pop_cnt_r <= '0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      count_r   <= count_s;
      iss_cnt_r <= iss_cnt_s;
      pop_cnt_r <= pop_cnt_s;
      done_r    <= done_s;
    end
  end

  // Read-latency capture into the output FIFO; in-flight data is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      occ_r      <= 2'd0;
      fifo_r[0]  <= '0;
      fifo_r[1]  <= '0;
      fifo_r[2]  <= '0;
    end else begin
      inflight_r <= ce_s;
      if (push_s) begin
        fifo_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Output drive, all derived directly from registered state.
  always_comb begin
    mem_ce   = ce_s;
    mem_addr = addr_r;
    m_valid  = (occ_r != 2'd0);
    m_data   = fifo_r[rd_ptr_r];
    m_last   = last_s;
    busy     = (state_r != ST_IDLE);
    done     = done_r;
  end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed plus randomized bench for weight_stream_reader with a behavioural memory
// and a queue-based model of the expected address and data sequences.
module tb_weight_stream_reader;

  localparam int DEPTH = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  count;
  logic        mem_ce;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [DEPTH];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int first_ce, first_valid, done_cyc, last_cyc, done_cnt, stall_ce, stall_end;
  int gap_from, busy_hits;
  bit gap_on = 1'b0;
  bit hold_pending = 1'b0;
  logic [15:0] hold_data;
  logic busy_obs;

  weight_stream_reader #(.RAM_WIDTH(16), .RAM_DEPTH(DEPTH), .RAM_ADDR(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port RAM read port: registered data, one cycle latency.
  always @(posedge clk) begin
    if (mem_ce && mem_addr < 9'd400) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    int e;
    busy_obs = busy;
    if (busy) busy_hits++;
    if (mem_ce) begin
      if (first_ce < 0) first_ce = cyc;
      if (cyc < stall_end) stall_ce++;
      chk("addr_range", 32'(mem_addr < 9'd400), 32'd1);
      if (exp_addr_q.size() == 0) chk("ce_unexpected", 32'd1, 32'd0);
      else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (hold_pending) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_data));
    end
    if (gap_on && cyc >= gap_from && exp_data_q.size() > 0) chk("no_gap", 32'(m_valid), 32'd1);
    chk("valid_unexp", 32'(m_valid && exp_data_q.size() == 0), 32'd0);
    chk("m_last", 32'(m_last), 32'(m_valid && exp_data_q.size() == 1));
    if (m_valid && m_ready && exp_data_q.size() > 0) begin
      e = exp_data_q.pop_front();
      chk("m_data", 32'(m_data), 32'(e));
      if (exp_data_q.size() == 0) last_cyc = cyc;
    end
    hold_pending = m_valid && !m_ready;
    hold_data = m_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int k, input int stall);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k >= stall);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: ready held high, 1: ready low for 'stall' cycles then high, 2: random ready
  task automatic run_cmd(input int b, input int n, input int mode, input int stall,
                         input bit intrude, input bit chain_in, input bit chain_out);
    int s;
    int k;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back((b + i) % DEPTH);
      exp_data_q.push_back(100 + ((b + i) % DEPTH));
    end
    first_ce = -1; first_valid = -1; done_cyc = -1; last_cyc = -1; stall_ce = 0;
    s = cyc;
    stall_end = (mode == 1) ? s + stall : -1;
    gap_on = (mode != 2);
    gap_from = (mode == 1) ? s + stall : s + 3;
    start = 1'b1; base_addr = 9'(b); count = 10'(n); m_ready = ready_for(mode, 0, stall);
    done_cnt = 0;
    tick();
    start = 1'b0;
    chk("busy_at_start", 32'(busy_obs), 32'd0);
    if (chain_in) chk("done_in_start_cycle", 32'(done_cnt), 32'd1);
    done_cnt = 0;
    k = 1;
    while (((chain_out && last_cyc < 0) || (!chain_out && done_cnt == 0)) && k < n * 20 + 50) begin
      m_ready = ready_for(mode, k, stall);
      if (intrude && k == 2) begin
        start = 1'b1; base_addr = 9'd50; count = 10'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      if (done_cnt == 0) chk("busy", 32'(busy_obs), 32'd1);
      else chk("busy_end", 32'(busy_obs), 32'd0);
    end
    start = 1'b0;
    chk("first_ce", 32'(first_ce), 32'(s + 1));
    chk("first_valid", 32'(first_valid), 32'(s + 3));
    chk("words_left", 32'(exp_data_q.size()), 32'd0);
    chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
    if (mode == 1) chk("stall_ce", 32'(stall_ce), 32'd3);
    gap_on = 1'b0;
    stall_end = -1;
    if (!chain_out) begin
      chk("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
      m_ready = 1'b1;
      tick();
      chk("done_once", 32'(done_cnt), 32'd1);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int s;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 100);
    rst_n = 1'b0; start = 1'b0; base_addr = 9'd0; count = 10'd0; m_ready = 1'b0;
    first_ce = -1; first_valid = -1; done_cyc = -1; last_cyc = -1;
    done_cnt = 0; stall_ce = 0; stall_end = -1; gap_from = 0; busy_hits = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    run_cmd(10, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(398, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(0, 8, 1, 10, 1'b0, 1'b0, 1'b0);

    // Zero-length command: only a done pulse.
    s = cyc; done_cnt = 0; done_cyc = -1; busy_hits = 0;
    start = 1'b1; base_addr = 9'd30; count = 10'd0; m_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_done_cyc", 32'(done_cyc), 32'(s + 1));
    chk("zero_busy", 32'(busy_hits), 32'd0);

    run_cmd(20, 6, 0, 0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: second start issued in the done cycle of the first.
    run_cmd(100, 3, 0, 0, 1'b0, 1'b0, 1'b1);
    run_cmd(200, 3, 0, 0, 1'b0, 1'b1, 1'b0);

    // Reset while a read is in flight and a word is buffered.
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(i);
    start = 1'b1; base_addr = 9'd0; count = 10'd8; m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_last", 32'(m_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    hold_pending = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(5, 2, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 2, 0,
              1'b0, 1'b0, 1'b0);
    end
    run_cmd(int'($urandom_range(0, DEPTH - 1)), DEPTH, 2, 0, 1'b0, 1'b0, 1'b0);

    busy_hits = 0;
    repeat (5) tick();
    chk("idle_busy", 32'(busy_hits), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
